// File: rtl/ysyx_22050019_axi_sram.sv
// Single-beat AXI-lite style slave memory for the LSU data port.
// The write (AW/W/B) and read (AR/R) channels run as independent state
// machines over one word-organised array with byte-strobe writes. Response
// latency on each channel is set by a parameter. Every output is a register.
module ysyx_22050019_axi_sram #(
    parameter int unsigned           ADDR_WIDTH = 64,
    parameter int unsigned           DATA_WIDTH = 64,
    parameter int unsigned           DEPTH      = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 64'h8000_0000,
    parameter int unsigned           RD_LATENCY = 1,
    parameter int unsigned           WR_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_axi_aw_valid,
    output logic                    s_axi_aw_ready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_aw_addr,
    input  logic                    s_axi_w_valid,
    output logic                    s_axi_w_ready,
    input  logic [DATA_WIDTH-1:0]   s_axi_w_data,
    input  logic [DATA_WIDTH/8-1:0] s_axi_w_strb,
    output logic                    s_axi_b_valid,
    input  logic                    s_axi_b_ready,
    output logic [1:0]              s_axi_b_resp,
    input  logic                    s_axi_ar_valid,
    output logic                    s_axi_ar_ready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_ar_addr,
    output logic                    s_axi_r_valid,
    input  logic                    s_axi_r_ready,
    output logic [DATA_WIDTH-1:0]   s_axi_r_data,
    output logic [1:0]              s_axi_r_resp
);

    localparam int unsigned           NBYTES = DATA_WIDTH / 8;
    localparam int unsigned           IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] SPAN   = ADDR_WIDTH'(DEPTH) << 3;
    localparam logic [1:0]            OKAY   = 2'b00;
    localparam logic [1:0]            DECERR = 2'b11;

    // The low three address bits are dropped: the master extracts bytes itself.
    function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >= BASE_ADDR) && ((addr - BASE_ADDR) < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 3);
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;

    w_state_t         w_state_reg;
    logic             aw_hit_reg;
    logic [IDX_W-1:0] aw_idx_reg;
    logic [3:0]       w_cnt_reg;
    logic             w_fire;

    assign w_fire = (w_state_reg == W_DATA) && s_axi_w_valid && s_axi_w_ready;

    // Write FSM: accept the address, then the data, then hold B until taken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state_reg    <= W_IDLE;
            s_axi_aw_ready <= 1'b1;
            s_axi_w_ready  <= 1'b0;
            s_axi_b_valid  <= 1'b0;
            s_axi_b_resp   <= OKAY;
            w_cnt_reg      <= 4'd0;
            aw_hit_reg     <= 1'b0;
            aw_idx_reg     <= '0;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (s_axi_aw_valid && s_axi_aw_ready) begin
                        aw_hit_reg     <= addr_hit(s_axi_aw_addr);
                        aw_idx_reg     <= addr_idx(s_axi_aw_addr);
                        s_axi_aw_ready <= 1'b0;
                        s_axi_w_ready  <= 1'b1;
                        w_state_reg    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        s_axi_w_ready <= 1'b0;
                        s_axi_b_resp  <= aw_hit_reg ? OKAY : DECERR;
                        if (WR_LATENCY == 0) begin
                            s_axi_b_valid <= 1'b1;
                            w_state_reg   <= W_RESP;
                        end else begin
                            w_cnt_reg   <= 4'(WR_LATENCY);
                            w_state_reg <= W_WAIT;
                        end
                    end
                end
                W_WAIT: begin
                    w_cnt_reg <= w_cnt_reg - 4'd1;
                    if (w_cnt_reg == 4'd1) begin
                        s_axi_b_valid <= 1'b1;
                        w_state_reg   <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_axi_b_valid && s_axi_b_ready) begin
                        s_axi_b_valid  <= 1'b0;
                        s_axi_b_resp   <= OKAY;
                        s_axi_aw_ready <= 1'b1;
                        w_state_reg    <= W_IDLE;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    // Array write on the W handshake; a reset edge suppresses the commit.
    always_ff @(posedge clk) begin
        if (rst && w_fire && aw_hit_reg) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (s_axi_w_strb[b]) begin
                    mem[aw_idx_reg][b*8 +: 8] <= s_axi_w_data[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    r_state_t              r_state_reg;
    logic [ADDR_WIDTH-1:0] ar_addr_reg;
    logic [3:0]            r_cnt_reg;
    logic [ADDR_WIDTH-1:0] rd_sel_addr;
    logic                  rd_hit;
    logic [IDX_W-1:0]      rd_idx;

    // Zero-latency reads capture straight from the AR bus; otherwise from the latch.
    always_comb begin
        rd_sel_addr = (r_state_reg == R_IDLE) ? s_axi_ar_addr : ar_addr_reg;
    end

    assign rd_hit = addr_hit(rd_sel_addr);
    assign rd_idx = addr_idx(rd_sel_addr);

    // Read FSM: count down the latency, capture the word, hold R until taken.
    // Capturing with a non-blocking read gives read-before-write on a same-edge collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_reg    <= R_IDLE;
            s_axi_ar_ready <= 1'b1;
            s_axi_r_valid  <= 1'b0;
            s_axi_r_data   <= '0;
            s_axi_r_resp   <= OKAY;
            r_cnt_reg      <= 4'd0;
            ar_addr_reg    <= '0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (s_axi_ar_valid && s_axi_ar_ready) begin
                        ar_addr_reg    <= s_axi_ar_addr;
                        s_axi_ar_ready <= 1'b0;
                        if (RD_LATENCY == 0) begin
                            s_axi_r_data  <= rd_hit ? mem[rd_idx] : '0;
                            s_axi_r_resp  <= rd_hit ? OKAY : DECERR;
                            s_axi_r_valid <= 1'b1;
                            r_state_reg   <= R_DATA;
                        end else begin
                            r_cnt_reg   <= 4'(RD_LATENCY);
                            r_state_reg <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    r_cnt_reg <= r_cnt_reg - 4'd1;
                    if (r_cnt_reg == 4'd1) begin
                        s_axi_r_data  <= rd_hit ? mem[rd_idx] : '0;
                        s_axi_r_resp  <= rd_hit ? OKAY : DECERR;
                        s_axi_r_valid <= 1'b1;
                        r_state_reg   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi_r_valid && s_axi_r_ready) begin
                        s_axi_r_valid  <= 1'b0;
                        s_axi_r_data   <= '0;
                        s_axi_r_resp   <= OKAY;
                        s_axi_ar_ready <= 1'b1;
                        r_state_reg    <= R_IDLE;
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050019_axi_sram.sv
// Directed bench for the AXI-lite SRAM slave. A sparse word model predicts
// read data and responses; a negedge monitor checks the live outputs against
// it whenever a response is valid, and the directed steps pin latencies,
// handshake timing and literal data values.
module tb_ysyx_22050019_axi_sram;

    localparam int          RDL   = 4;
    localparam int          WRL   = 2;
    localparam int          DEPTH = 4096;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        aw_valid = 1'b0, aw_ready;
    logic [63:0] aw_addr = '0;
    logic        w_valid = 1'b0, w_ready;
    logic [63:0] w_data = '0;
    logic [7:0]  w_strb = '0;
    logic        b_valid, b_ready = 1'b0;
    logic [1:0]  b_resp;
    logic        ar_valid = 1'b0, ar_ready;
    logic [63:0] ar_addr = '0;
    logic        r_valid, r_ready = 1'b0;
    logic [63:0] r_data;
    logic [1:0]  r_resp;

    always #5 clk = ~clk;

    ysyx_22050019_axi_sram #(
        .ADDR_WIDTH(64), .DATA_WIDTH(64), .DEPTH(DEPTH), .BASE_ADDR(BASE),
        .RD_LATENCY(RDL), .WR_LATENCY(WRL)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_aw_valid(aw_valid), .s_axi_aw_ready(aw_ready), .s_axi_aw_addr(aw_addr),
        .s_axi_w_valid(w_valid), .s_axi_w_ready(w_ready), .s_axi_w_data(w_data), .s_axi_w_strb(w_strb),
        .s_axi_b_valid(b_valid), .s_axi_b_ready(b_ready), .s_axi_b_resp(b_resp),
        .s_axi_ar_valid(ar_valid), .s_axi_ar_ready(ar_ready), .s_axi_ar_addr(ar_addr),
        .s_axi_r_valid(r_valid), .s_axi_r_ready(r_ready), .s_axi_r_data(r_data), .s_axi_r_resp(r_resp)
    );

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 1'b0;

    logic [63:0] model_mem [int];
    logic [63:0] exp_rdata = '0;
    logic [1:0]  exp_rresp = 2'b00;
    logic [1:0]  exp_bresp = 2'b00;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic bit model_hit(input logic [63:0] a);
        return (a >= BASE) && (a < BASE + 64'(DEPTH * 8));
    endfunction

    function automatic void model_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        int          idx;
        logic [63:0] word;
        if (!model_hit(a)) return;
        idx  = int'((a - BASE) >> 3);
        word = model_mem.exists(idx) ? model_mem[idx] : 64'h0;
        for (int b = 0; b < 8; b++) begin
            if (s[b]) word[b*8 +: 8] = d[b*8 +: 8];
        end
        model_mem[idx] = word;
    endfunction

    function automatic void model_read(input logic [63:0] a, output logic [63:0] d, output logic [1:0] r);
        int idx;
        d = 64'h0;
        r = 2'b11;
        if (model_hit(a)) begin
            idx = int'((a - BASE) >> 3);
            d   = model_mem.exists(idx) ? model_mem[idx] : 64'h0;
            r   = 2'b00;
        end
    endfunction

    // Live monitor: any valid response must match the model and hold its channel busy.
    always @(negedge clk) begin
        if (cmp_en) begin
            if (r_valid) begin
                check("r_data_live", r_data, exp_rdata);
                check("r_resp_live", 64'(r_resp), 64'(exp_rresp));
                check("ar_ready_while_r", 64'(ar_ready), 64'd0);
            end
            if (b_valid) begin
                check("b_resp_live", 64'(b_resp), 64'(exp_bresp));
                check("aw_ready_while_b", 64'(aw_ready), 64'd0);
            end
            if (aw_ready) begin
                check("w_ready_in_idle", 64'(w_ready), 64'd0);
            end
        end
    end

    // Counts clock edges from the handshake edge until the chosen valid rises.
    task automatic wait_valid(input bit is_read, input int exp_cycles, input string name);
        int cycles = 0;
        while (1) begin
            @(negedge clk);
            if ((is_read ? r_valid : b_valid) === 1'b1) break;
            if (cycles > 40) begin
                check({name, "_timeout"}, 64'd0, 64'd1);
                return;
            end
            @(posedge clk);
            cycles++;
        end
        check(name, 64'(cycles), 64'(exp_cycles));
    endtask

    task automatic write_txn(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                             input int hold, input logic [1:0] resp_exp);
        @(negedge clk);
        check("aw_ready_before_aw", 64'(aw_ready), 64'd1);
        aw_valid = 1'b1; aw_addr = a;
        w_valid = 1'b1; w_data = d; w_strb = s;
        b_ready = 1'b0;
        exp_bresp = model_hit(a) ? 2'b00 : 2'b11;
        @(posedge clk);
        @(negedge clk);
        aw_valid = 1'b0;
        check("w_ready_after_aw", 64'(w_ready), 64'd1);
        @(posedge clk);
        #1 w_valid = 1'b0;
        model_write(a, d, s);
        wait_valid(1'b0, WRL, "b_latency");
        check("b_resp", 64'(b_resp), 64'(resp_exp));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("b_valid_held", 64'(b_valid), 64'd1);
        end
        b_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_ready = 1'b0;
        check("b_valid_after_b", 64'(b_valid), 64'd0);
        check("aw_ready_after_b", 64'(aw_ready), 64'd1);
        $display("write addr=%h data=%h strb=%h resp=%0d", a, d, s, resp_exp);
    endtask

    task automatic read_txn(input logic [63:0] a, input int hold,
                            output logic [63:0] got, output logic [1:0] got_resp);
        @(negedge clk);
        check("ar_ready_before_ar", 64'(ar_ready), 64'd1);
        ar_valid = 1'b1; ar_addr = a;
        r_ready = 1'b0;
        model_read(a, exp_rdata, exp_rresp);
        @(posedge clk);
        #1 ar_valid = 1'b0;
        wait_valid(1'b1, RDL, "r_latency");
        got = r_data;
        got_resp = r_resp;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("r_valid_held", 64'(r_valid), 64'd1);
            check("r_data_held", r_data, got);
        end
        r_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_ready = 1'b0;
        check("r_valid_after_r", 64'(r_valid), 64'd0);
        check("r_data_after_r", r_data, 64'd0);
        check("ar_ready_after_r", 64'(ar_ready), 64'd1);
        $display("read  addr=%h data=%h resp=%0d", a, got, got_resp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        logic [1:0]  r;

        // Reset held three cycles
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("rst_aw_ready", 64'(aw_ready), 64'd1);
        check("rst_ar_ready", 64'(ar_ready), 64'd1);
        check("rst_w_ready", 64'(w_ready), 64'd0);
        check("rst_b_valid", 64'(b_valid), 64'd0);
        check("rst_r_valid", 64'(r_valid), 64'd0);
        check("rst_r_data", r_data, 64'd0);
        check("rst_b_resp", 64'(b_resp), 64'd0);
        cmp_en = 1'b1;

        // Full write then read back
        write_txn(64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0, 2'b00);
        read_txn(64'h8000_0010, 0, d, r);
        check("full_rd_data", d, 64'h1122_3344_5566_7788);
        check("full_rd_resp", 64'(r), 64'd0);

        // Low-half byte strobe
        write_txn(64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 0, 2'b00);
        read_txn(64'h8000_0010, 0, d, r);
        check("strb_rd_data", d, 64'h1122_3344_AAAA_AAAA);
        read_txn(64'h8000_0013, 0, d, r);
        check("unaligned_rd_data", d, 64'h1122_3344_AAAA_AAAA);

        // Backpressure on B and R
        write_txn(64'h8000_0018, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 4, 2'b00);
        read_txn(64'h8000_0018, 5, d, r);
        check("bp_rd_data", d, 64'hDEAD_BEEF_CAFE_F00D);

        // Zero strobe leaves the word intact
        write_txn(64'h8000_0018, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, 2'b00);
        read_txn(64'h8000_0018, 0, d, r);
        check("strb0_rd_data", d, 64'hDEAD_BEEF_CAFE_F00D);

        // Decode errors at both edges of the window
        write_txn(64'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 2'b00);
        write_txn(64'h8000_7FF8, 64'hFEDC_BA98_7654_3210, 8'hFF, 0, 2'b00);
        write_txn(64'h7FFF_FFF8, 64'h5555_5555_5555_5555, 8'hFF, 0, 2'b11);
        write_txn(64'h8000_8000, 64'h6666_6666_6666_6666, 8'hFF, 0, 2'b11);
        read_txn(64'h7FFF_FFF8, 0, d, r);
        check("decerr_lo_data", d, 64'd0);
        check("decerr_lo_resp", 64'(r), 64'd3);
        read_txn(64'h8000_8000, 0, d, r);
        check("decerr_hi_data", d, 64'd0);
        check("decerr_hi_resp", 64'(r), 64'd3);
        read_txn(64'h8000_0000, 0, d, r);
        check("word0_intact", d, 64'h0123_4567_89AB_CDEF);
        read_txn(64'h8000_7FF8, 0, d, r);
        check("wordlast_intact", d, 64'hFEDC_BA98_7654_3210);

        // Same-edge collision: read capture and W handshake on one edge
        write_txn(64'h8000_0020, 64'h0A0B_0C0D_0E0F_1011, 8'hFF, 0, 2'b00);
        @(negedge clk);
        ar_valid = 1'b1; ar_addr = 64'h8000_0020;
        aw_valid = 1'b1; aw_addr = 64'h8000_0020;
        r_ready = 1'b1; b_ready = 1'b1;
        model_read(64'h8000_0020, exp_rdata, exp_rresp);
        exp_bresp = 2'b00;
        @(posedge clk);
        @(negedge clk);
        ar_valid = 1'b0; aw_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        w_valid = 1'b1; w_data = 64'h5A5A_5A5A_5A5A_5A5A; w_strb = 8'hFF;
        @(posedge clk);
        model_write(64'h8000_0020, 64'h5A5A_5A5A_5A5A_5A5A, 8'hFF);
        @(negedge clk);
        w_valid = 1'b0;
        check("collision_r_valid", 64'(r_valid), 64'd1);
        check("collision_old_data", r_data, 64'h0A0B_0C0D_0E0F_1011);
        repeat (4) @(negedge clk);
        r_ready = 1'b0; b_ready = 1'b0;
        check("collision_r_done", 64'(r_valid), 64'd0);
        check("collision_b_done", 64'(b_valid), 64'd0);
        $display("collision addr=%h old=%h", 64'h8000_0020, 64'h0A0B_0C0D_0E0F_1011);
        read_txn(64'h8000_0020, 0, d, r);
        check("collision_new_data", d, 64'h5A5A_5A5A_5A5A_5A5A);

        // Reset while the write sits in W_RESP and the read in R_WAIT
        @(negedge clk);
        aw_valid = 1'b1; aw_addr = 64'h8000_0028;
        w_valid = 1'b1; w_data = 64'h7777_8888_9999_AAAA; w_strb = 8'hFF;
        b_ready = 1'b0; exp_bresp = 2'b00;
        @(posedge clk);
        @(negedge clk);
        aw_valid = 1'b0;
        @(posedge clk);
        model_write(64'h8000_0028, 64'h7777_8888_9999_AAAA, 8'hFF);
        @(negedge clk);
        w_valid = 1'b0;
        ar_valid = 1'b1; ar_addr = 64'h8000_0010; r_ready = 1'b0;
        model_read(64'h8000_0010, exp_rdata, exp_rresp);
        @(posedge clk);
        @(negedge clk);
        ar_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("b_valid_before_rst", 64'(b_valid), 64'd1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("midrst_r_valid", 64'(r_valid), 64'd0);
            check("midrst_b_valid", 64'(b_valid), 64'd0);
            check("midrst_aw_ready", 64'(aw_ready), 64'd1);
            check("midrst_ar_ready", 64'(ar_ready), 64'd1);
            @(negedge clk);
        end
        $display("reset mid-transaction applied");
        read_txn(64'h8000_0028, 0, d, r);
        check("midrst_committed", d, 64'h7777_8888_9999_AAAA);
        read_txn(64'h8000_0010, 0, d, r);
        check("midrst_prior_word", d, 64'h1122_3344_AAAA_AAAA);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
